// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues sequential fetches under a credit cap,
// buffers in-order responses for decode and squashes stale fetches on redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign_err
);
  localparam int              CW         = $clog2(MAX_OUT + 1);
  localparam int              PW         = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(MAX_OUT);
  localparam logic [PW-1:0]   PTR_LAST   = PW'(MAX_OUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_next;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] drop_cnt, drop_next;
  logic [CW-1:0] buf_cnt;
  logic [CW:0]   credit;
  logic [PW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
  logic [31:0]   tag_mem  [MAX_OUT];
  logic [31:0]   data_mem [MAX_OUT];
  logic [31:0]   pc_mem   [MAX_OUT];

  logic redirect_ok, req_fire, rsp_fire, rsp_drop, buf_push, buf_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal gets a value on every path through this block, so no latches form.
  always_comb begin
    redirect_ok      = redirect_valid && (redirect_pc[1:0] == 2'b00);
    credit           = {1'b0, outstanding} + {1'b0, buf_cnt};
    imem_req_valid   = (state == RUN) && (credit < CREDIT_MAX) && !redirect_valid;
    req_fire         = imem_req_valid && imem_req_ready;
    rsp_fire         = imem_rsp_valid && (outstanding != '0);
    rsp_drop         = rsp_fire && (drop_cnt != '0);
    buf_push         = rsp_fire && !rsp_drop && !redirect_ok;
    inst_valid       = (buf_cnt != '0);
    buf_pop          = inst_valid && inst_ready && !redirect_ok;
    outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
    // On redirect every fetch still in flight belongs to the old path.
    drop_next        = redirect_ok ? outstanding_next : drop_cnt - CW'(rsp_drop);

    state_next = state;
    unique case (state)
      IDLE:    state_next = RUN;
      RUN:     if (redirect_ok && (drop_next != '0)) state_next = FLUSH;
      FLUSH:   if (drop_next == '0) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign imem_req_addr = pc;
  assign inst          = inst_valid ? data_mem[buf_rd] : '0;
  assign inst_pc       = inst_valid ? pc_mem[buf_rd]   : '0;

  // NOTE: registered state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      tag_wr       <= '0;
      tag_rd       <= '0;
      buf_wr       <= '0;
      buf_rd       <= '0;
      buf_cnt      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && !redirect_ok;
      outstanding  <= outstanding_next;
      drop_cnt     <= drop_next;

      if (redirect_ok)   pc <= redirect_pc;
      else if (req_fire) pc <= pc + 32'd4;

      if (req_fire) tag_wr <= ptr_inc(tag_wr);
      if (rsp_fire) tag_rd <= ptr_inc(tag_rd);

      if (redirect_ok) begin
        buf_wr  <= '0;
        buf_rd  <= '0;
        buf_cnt <= '0;
      end else begin
        if (buf_push) buf_wr <= ptr_inc(buf_wr);
        if (buf_pop)  buf_rd <= ptr_inc(buf_rd);
        buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; occupancy is defined solely by pointers and counters.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= pc;
    if (buf_push) begin
      data_mem[buf_wr] <= imem_rsp_data;
      pc_mem[buf_wr]   <= tag_mem[tag_rd];
    end
  end

endmodule
